selfcomp_divergence_monitor: RTL and testbench
==============================================

# selfcomp_divergence_monitor

Parametrised sequencer and checker for two-copy self-composition BMC harnesses of the Sodor cores. It generates the shared core reset and a one-cycle state-equality sync pulse for both copies, then compares NCH observation channels between copy A and copy B inside a programmable check window. It records sticky per-channel divergence, the first divergent channel and cycle, and a final pass/done verdict. The harness ties `sync_pulse` to its equality assumption and `done`/`diverge` to its assertion.

## Interface
- `NCH`, default 4: number of observed channel pairs (≥1).
- `W`, default 32: data width per channel.
- `RESET_CYCLES`, default 2: cycles of core reset after `reset` is released (≥1).
- `CHECK_START`, default 4: first cycle of the check window.
- `CHECK_END`, default 12: last cycle of the check window. Required: RESET_CYCLES < CHECK_START ≤ CHECK_END < 2^CNT_W − 1.
- `CNT_W`, default 8: cycle counter width.

Ports (clock and reset first):
- `clk` in 1: the only clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-high. Clears all state.
- `mode` in 1: 0 = valid-gated compare; 1 = strict compare. Sampled every cycle.
- `ch_mask` in NCH: bit i = 1 enables checking of channel i.
- `ch_valid_a` in NCH: per-channel valid, copy A.
- `ch_data_a` in NCH*W: channel i occupies bits [i*W +: W], copy A.
- `ch_valid_b` in NCH: per-channel valid, copy B.
- `ch_data_b` in NCH*W: channel data, copy B.
- `core_reset` out 1: reset to both core copies.
- `sync_pulse` out 1: single-cycle strobe at which copy states are asserted equal.
- `check_en` out 1: high inside the check window.
- `diverge_now` out 1: combinational, a masked divergence this cycle while `check_en` = 1.
- `diverge` out 1: sticky, a divergence has been captured.
- `div_vec` out NCH: sticky per-channel divergence.
- `first_chan` out max(1,$clog2(NCH)): index of the first divergent channel.
- `first_cycle` out CNT_W: value of `cyc` at the first divergence.
- `done` out 1: check window has elapsed.
- `pass` out 1: `done` & !`diverge`.

## Operation
- Internal `cyc` register, CNT_W bits. Reset to 0, +1 per cycle, frozen once state = DONE. It never wraps, because CHECK_END < 2^CNT_W − 1.
- FSM states and transitions:
  - RST: `cyc` < RESET_CYCLES. Moves to SYNC when `cyc` = RESET_CYCLES − 1.
  - SYNC: exactly one cycle, `cyc` = RESET_CYCLES. Moves to RUN.
  - RUN: waits. Moves to CHECK when `cyc` = CHECK_START − 1. This is skipped when CHECK_START = RESET_CYCLES + 1.
  - CHECK: active while CHECK_START ≤ `cyc` ≤ CHECK_END. Moves to DONE after `cyc` = CHECK_END.
  - DONE: absorbing until `reset`.
- Output decode:
  - `core_reset` = `reset` | (state == RST).
  - `sync_pulse` = (state == SYNC).
  - `check_en` = (state == CHECK).
  - `done` = (state == DONE).
- Per-channel divergence d[i]:
  - mode 0: (va ^ vb) | (va & vb & (da != db)). Data is ignored when both copies are invalid.
  - mode 1: (va ^ vb) | (da != db).
  - Masked: m[i] = d[i] & ch_mask[i].
- `diverge_now` = `check_en` & |m.
- Capture on every cycle with `check_en` = 1:
  - `div_vec` <= `div_vec` | m.
  - If `diverge` = 0 and |m = 1: `diverge` <= 1, `first_chan` <= lowest set index of m, `first_cycle` <= `cyc`.
  - Later divergences update `div_vec` only. `first_*` is never overwritten until `reset`.
- Mismatches outside CHECK, including during RST and SYNC, are ignored.
- Reset values: `core_reset` 1, `sync_pulse` 0, `check_en` 0, `diverge` 0, `div_vec` 0, `first_chan` 0, `first_cycle` 0, `done` 0, `pass` 0. State = RST, `cyc` = 0.

## Timing
- All outputs except `diverge_now` decode from registers only, so there are no combinational paths from the `ch_*` inputs to them.
- `diverge_now` is combinational from the `ch_*`, `mode` and `ch_mask` inputs in the same cycle.
- `diverge`, `div_vec` and `first_*` update one cycle after the divergent sample.
- Defaults, with cycle 0 as the first cycle after `reset` is released:
  - `core_reset` is high on cycles 0–1.
  - `sync_pulse` is high on cycle 2.
  - `check_en` is high on cycles 4–12.
  - `done` and `pass` are valid from cycle 13.
- A divergence sampled on cycle 12 is reflected in `diverge` on cycle 13, the same cycle `done` rises. `pass` therefore never glitches high.
- Simultaneous divergences on several channels: all are set in `div_vec`, and the lowest index is reported in `first_chan`.
- `reset` asserted mid-operation:
  - `core_reset` is high in that same cycle.
  - All state clears at the edge.
  - The sequence restarts at `cyc` = 0 after release.
- `ch_mask` and `mode` changes take effect in the same cycle.

## Test plan
All scenarios use the default parameters.
1. Identical A/B streams, `ch_mask` = 4'hF → `core_reset` high on cycles 0–1, `sync_pulse` high on cycle 2 only, `check_en` high on cycles 4–12, `done` = 1 and `pass` = 1 from cycle 13, `diverge` = 0.
2. mode 0, `ch_valid_a[2]` = 1 and `ch_valid_b[2]` = 0 on cycle 7 → `diverge_now` = 1 on cycle 7; from cycle 8 `diverge` = 1, `first_chan` = 2, `first_cycle` = 7, `div_vec` = 4'b0100; `pass` = 0 at cycle 13.
3. Both copies invalid on ch0 with data 32'h1 vs 32'h2 on cycle 6: mode 0 → no divergence; mode 1 → `first_chan` = 0, `first_cycle` = 6.
4. ch1 and ch3 diverge on cycle 5, then ch0 on cycle 6 → `first_chan` = 1, `first_cycle` = 5, `div_vec` = 4'b1011 from cycle 7.
5. Mismatch on ch0 at cycles 3 and 13, plus a mismatch on ch2 at cycle 8 with `ch_mask` = 4'b1011 → `diverge` stays 0 and `pass` = 1.
6. Divergence on cycle 5, then `reset` pulsed on cycle 9 → all outputs return to their reset values on cycle 10 and the full sequence replays, with `sync_pulse` two cycles after release.

Source files
------------

// File: rtl/selfcomp_divergence_monitor.sv
`default_nettype none
// ============================================================================
// Module      : selfcomp_divergence_monitor
// Description : Sequencer and checker for two-copy self-composition BMC
//               harnesses. Drives the shared core reset, emits a one-cycle
//               state-equality sync strobe, then compares NCH observation
//               channels between copy A and copy B inside a check window.
//               Records sticky per-channel divergence, the first divergent
//               channel/cycle and a final done/pass verdict.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        synchronous active-high reset
//   mode         in   1        0 = valid-gated compare, 1 = strict compare
//   ch_mask      in   NCH      per-channel check enable
//   ch_valid_a   in   NCH      per-channel valid, copy A
//   ch_data_a    in   NCH*W    channel i at [i*W +: W], copy A
//   ch_valid_b   in   NCH      per-channel valid, copy B
//   ch_data_b    in   NCH*W    channel i at [i*W +: W], copy B
//   core_reset   out  1        reset to both core copies
//   sync_pulse   out  1        single-cycle state-equality strobe
//   check_en     out  1        high inside the check window
//   diverge_now  out  1        combinational masked divergence this cycle
//   diverge      out  1        sticky divergence flag
//   div_vec      out  NCH      sticky per-channel divergence
//   first_chan   out  FC_W     lowest channel of the first divergence
//   first_cycle  out  CNT_W    cycle count of the first divergence
//   done         out  1        check window has elapsed
//   pass         out  1        done and no divergence
// ============================================================================
module selfcomp_divergence_monitor #(
    parameter int NCH          = 4,
    parameter int W            = 32,
    parameter int RESET_CYCLES = 2,
    parameter int CHECK_START  = 4,
    parameter int CHECK_END    = 12,
    parameter int CNT_W        = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      mode,
    input  logic [NCH-1:0]                            ch_mask,
    input  logic [NCH-1:0]                            ch_valid_a,
    input  logic [NCH*W-1:0]                          ch_data_a,
    input  logic [NCH-1:0]                            ch_valid_b,
    input  logic [NCH*W-1:0]                          ch_data_b,
    output logic                                      core_reset,
    output logic                                      sync_pulse,
    output logic                                      check_en,
    output logic                                      diverge_now,
    output logic                                      diverge,
    output logic [NCH-1:0]                            div_vec,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  first_chan,
    output logic [CNT_W-1:0]                          first_cycle,
    output logic                                      done,
    output logic                                      pass
);

    localparam int c_FC_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [2:0] c_ST_RST   = 3'd0;
    localparam logic [2:0] c_ST_SYNC  = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_CHECK = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    // Counter values at which the FSM leaves its current state.
    localparam logic [CNT_W-1:0] c_RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CHK_PRE   = CNT_W'(CHECK_START - 1);
    localparam logic [CNT_W-1:0] c_CHK_LAST  = CNT_W'(CHECK_END);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cyc;
    logic              r_diverge;
    logic [NCH-1:0]    r_div_vec;
    logic [c_FC_W-1:0] r_first_chan;
    logic [CNT_W-1:0]  r_first_cycle;

    logic [NCH-1:0]    w_d;
    logic [NCH-1:0]    w_m;
    logic              w_any;
    logic [c_FC_W-1:0] w_low;
    logic              w_check_en;

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RST: begin
                if (r_cyc == c_RST_LAST) w_state_nxt = c_ST_SYNC;
            end
            c_ST_SYNC: begin
                // With no gap between sync and the window, go straight to CHECK.
                if (r_cyc == c_CHK_PRE) w_state_nxt = c_ST_CHECK;
                else                    w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (r_cyc == c_CHK_PRE) w_state_nxt = c_ST_CHECK;
            end
            c_ST_CHECK: begin
                if (r_cyc == c_CHK_LAST) w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_DONE;
            end
            default: begin
                w_state_nxt = c_ST_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RST;
            r_cyc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Counter freezes in DONE; the window bound keeps it from wrapping.
            if (r_state != c_ST_DONE) r_cyc <= r_cyc + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel divergence
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic         w_va;
            logic         w_vb;
            logic         w_ne;
            assign w_va = ch_valid_a[gi];
            assign w_vb = ch_valid_b[gi];
            assign w_ne = (ch_data_a[gi*W +: W] != ch_data_b[gi*W +: W]);
            // Valid-gated mode ignores data when both copies are idle.
            assign w_d[gi] = mode ? ((w_va ^ w_vb) | w_ne)
                                  : ((w_va ^ w_vb) | (w_va & w_vb & w_ne));
        end
    endgenerate

    assign w_m   = w_d & ch_mask;
    assign w_any = |w_m;

    // Lowest set index: scan downward so the last hit wins.
    always_comb begin
        w_low = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_m[i]) w_low = i[c_FC_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Capture
    // ------------------------------------------------------------------
    assign w_check_en = (r_state == c_ST_CHECK);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_diverge     <= 1'b0;
            r_div_vec     <= '0;
            r_first_chan  <= '0;
            r_first_cycle <= '0;
        end else if (w_check_en) begin
            r_div_vec <= r_div_vec | w_m;
            if (!r_diverge && w_any) begin
                r_diverge     <= 1'b1;
                r_first_chan  <= w_low;
                r_first_cycle <= r_cyc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign core_reset  = reset | (r_state == c_ST_RST);
    assign sync_pulse  = (r_state == c_ST_SYNC);
    assign check_en    = w_check_en;
    assign diverge_now = w_check_en & w_any;
    assign diverge     = r_diverge;
    assign div_vec     = r_div_vec;
    assign first_chan  = r_first_chan;
    assign first_cycle = r_first_cycle;
    assign done        = (r_state == c_ST_DONE);
    // diverge and done rise on the same edge, so pass cannot glitch high.
    assign pass        = (r_state == c_ST_DONE) & ~r_diverge;

endmodule
`default_nettype wire

// File: tb/tb_selfcomp_divergence_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_selfcomp_divergence_monitor
// Description : Self-checking bench for selfcomp_divergence_monitor with
//               default parameters. Directed scenarios plus randomized
//               traffic, compared against a cycle-indexed reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_selfcomp_divergence_monitor;

    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int CNT_W = 8;
    localparam int RST_CYC = 2;
    localparam int CHK_START = 4;
    localparam int CHK_END = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             mode;
    logic [NCH-1:0]   ch_mask;
    logic [NCH-1:0]   ch_valid_a;
    logic [NCH*W-1:0] ch_data_a;
    logic [NCH-1:0]   ch_valid_b;
    logic [NCH*W-1:0] ch_data_b;
    logic             core_reset;
    logic             sync_pulse;
    logic             check_en;
    logic             diverge_now;
    logic             diverge;
    logic [NCH-1:0]   div_vec;
    logic [1:0]       first_chan;
    logic [CNT_W-1:0] first_cycle;
    logic             done;
    logic             pass;

    selfcomp_divergence_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .ch_mask     (ch_mask),
        .ch_valid_a  (ch_valid_a),
        .ch_data_a   (ch_data_a),
        .ch_valid_b  (ch_valid_b),
        .ch_data_b   (ch_data_b),
        .core_reset  (core_reset),
        .sync_pulse  (sync_pulse),
        .check_en    (check_en),
        .diverge_now (diverge_now),
        .diverge     (diverge),
        .div_vec     (div_vec),
        .first_chan  (first_chan),
        .first_cycle (first_cycle),
        .done        (done),
        .pass        (pass)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cycles since reset release plus captured verdict.
    int       t;
    bit       m_div;
    bit [3:0] m_vec;
    int       m_fc;
    int       m_fcyc;

    task automatic model_clear();
        t = 0; m_div = 0; m_vec = '0; m_fc = 0; m_fcyc = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // Masked divergence of the current inputs, straight from the compare rules.
    function automatic bit [3:0] ref_mismatch();
        bit [3:0] r;
        bit va, vb, same, d;
        r = '0;
        for (int i = 0; i < NCH; i++) begin
            va   = ch_valid_a[i];
            vb   = ch_valid_b[i];
            same = (ch_data_a[i*W +: W] == ch_data_b[i*W +: W]);
            if (va != vb)     d = 1;
            else if (mode)    d = !same;
            else if (va)      d = !same;
            else              d = 0;
            r[i] = d && ch_mask[i];
        end
        return r;
    endfunction

    // Check every output for the current cycle, then advance one clock.
    task automatic tick();
        bit [3:0] mm;
        bit cen;
        int lo;
        #1;
        mm  = ref_mismatch();
        cen = (t >= CHK_START) && (t <= CHK_END);
        check("core_reset",  core_reset,  reset || (t < RST_CYC));
        check("sync_pulse",  sync_pulse,  t == RST_CYC);
        check("check_en",    check_en,    cen);
        check("diverge_now", diverge_now, cen && (mm != 0));
        check("diverge",     diverge,     m_div);
        check("div_vec",     div_vec,     m_vec);
        check("first_chan",  first_chan,  m_fc);
        check("first_cycle", first_cycle, m_fcyc);
        check("done",        done,        t > CHK_END);
        check("pass",        pass,        (t > CHK_END) && !m_div);
        if (reset) begin
            model_clear();
        end else begin
            if (cen && mm != 0) begin
                if (!m_div) begin
                    m_div = 1;
                    m_fcyc = t;
                    lo = 0;
                    while (!mm[lo]) lo++;
                    m_fc = lo;
                end
                m_vec |= mm;
            end
            t++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_same();
        for (int i = 0; i < NCH; i++) begin
            ch_valid_a[i] = 1'($urandom_range(0, 1));
            ch_data_a[i*W +: W] = $urandom;
        end
        ch_valid_b = ch_valid_a;
        ch_data_b  = ch_data_a;
    endtask

    task automatic inject(input int rate);
        for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, rate - 1) == 0) begin
                if ($urandom_range(0, 1) == 1) ch_valid_b[i] = ~ch_valid_b[i];
                else ch_data_b[i*W +: W] = ch_data_b[i*W +: W] ^ (32'h1 << $urandom_range(0, 31));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_same();
        tick();
        reset = 1'b0;
    endtask

    // Directed per-cycle overrides for each test-plan scenario.
    task automatic scen_override(input int sc);
        case (sc)
            2: if (t == 7) begin ch_valid_a[2] = 1'b1; ch_valid_b[2] = 1'b0; end
            3: if (t == 6) begin
                   ch_valid_a[0] = 1'b0; ch_valid_b[0] = 1'b0;
                   ch_data_a[0 +: W] = 32'h1; ch_data_b[0 +: W] = 32'h2;
               end
            4: begin
                   if (t == 5) begin
                       ch_valid_b[1] = ~ch_valid_a[1];
                       ch_valid_b[3] = ~ch_valid_a[3];
                   end
                   if (t == 6) ch_valid_b[0] = ~ch_valid_a[0];
               end
            5: begin
                   if (t == 3 || t == 13) ch_valid_b[0] = ~ch_valid_a[0];
                   if (t == 8) ch_valid_b[2] = ~ch_valid_a[2];
               end
            default: ;
        endcase
    endtask

    task automatic run_scen(input int sc, input bit md, input logic [3:0] msk);
        do_reset();
        mode = md;
        ch_mask = msk;
        for (int k = 0; k < 16; k++) begin
            drive_same();
            scen_override(sc);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; ch_mask = '1;
        ch_valid_a = '0; ch_valid_b = '0; ch_data_a = '0; ch_data_b = '0;
        @(posedge clk);
        @(negedge clk);
        model_clear();

        // 1: identical streams
        run_scen(1, 1'b0, 4'hF);
        check("s1_pass", pass, 1);
        check("s1_diverge", diverge, 0);

        // 2: valid mismatch on ch2 at cycle 7
        run_scen(2, 1'b0, 4'hF);
        check("s2_first_chan", first_chan, 2);
        check("s2_first_cycle", first_cycle, 7);
        check("s2_div_vec", div_vec, 4'b0100);
        check("s2_pass", pass, 0);

        // 3: both invalid with differing data
        run_scen(3, 1'b0, 4'hF);
        check("s3_mode0_diverge", diverge, 0);
        run_scen(3, 1'b1, 4'hF);
        check("s3_mode1_diverge", diverge, 1);
        check("s3_mode1_first_chan", first_chan, 0);
        check("s3_mode1_first_cycle", first_cycle, 6);

        // 4: simultaneous ch1/ch3 then ch0
        run_scen(4, 1'b0, 4'hF);
        check("s4_first_chan", first_chan, 1);
        check("s4_first_cycle", first_cycle, 5);
        check("s4_div_vec", div_vec, 4'b1011);

        // 5: mismatches outside window or masked
        run_scen(5, 1'b0, 4'b1011);
        check("s5_diverge", diverge, 0);
        check("s5_pass", pass, 1);

        // 6: divergence at 5, reset pulsed at 9, full replay
        do_reset();
        mode = 1'b0; ch_mask = 4'hF;
        for (int k = 0; k < 10; k++) begin
            drive_same();
            if (t == 5) ch_valid_b[1] = ~ch_valid_a[1];
            if (k == 9) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        check("s6_diverge_cleared", diverge, 0);
        for (int k = 0; k < 16; k++) begin
            drive_same();
            tick();
        end
        check("s6_replay_pass", pass, 1);

        // Randomized traffic, including mid-run resets and same-cycle
        // mode/mask changes.
        for (int s = 0; s < 12; s++) begin
            int n;
            do_reset();
            mode = 1'($urandom_range(0, 1));
            ch_mask = 4'($urandom_range(0, 15));
            n = $urandom_range(6, 20);
            for (int k = 0; k < n; k++) begin
                drive_same();
                inject(10);
                if ($urandom_range(0, 7) == 0) mode = ~mode;
                if ($urandom_range(0, 7) == 0) ch_mask = 4'($urandom_range(0, 15));
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
